rail_fence_ctrl: RTL and testbench
==================================

RAIL_FENCE_CTRL -- requirements
Module: rail_fence_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32: maximum stored message length in bytes, terminator excluded.
REQ-002 SHALL have parameter TERM, default 8'hFA: end-of-message byte value.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  ciphertext byte present on data.
REQ-006 SHALL have port in_ready  output  1  block accepts a byte; a byte transfers when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port data  input  8  ciphertext byte.
REQ-008 SHALL have port key  input  2  rail count: 2'b10 = 2 rails, 2'b11 = 3 rails, 2'b00/2'b01 = 1 rail (pass-through).
REQ-009 SHALL have port out_valid  output  1  plaintext byte present on data_c.
REQ-010 SHALL have port out_ready  input  1  sink accepts data_c; a byte transfers when out_valid && out_ready at a clk edge.
REQ-011 SHALL have port data_c  output  8  decrypted plaintext byte.
REQ-012 SHALL have port busy  output  1  high in SETUP and EMIT states.
REQ-013 SHALL have port err  output  1  one-cycle pulse on overflow.

Function
REQ-014 SHALL implement the FSM states LOAD, SETUP and EMIT; in_ready SHALL be 1 exactly in LOAD.
REQ-015 LOAD: each accepted byte other than TERM SHALL be written to buffer[L], where L is the current length, and L SHALL then increment.
REQ-016 SHALL latch key on the first accepted byte of a message and ignore key changes until the message is emitted.
REQ-017 SHALL track a zigzag rail index during LOAD and count per-rail lengths len0/len1/len2. For R rails, period P = 2(R-1); rail(i) = i mod P if (i mod P) < R, else P - (i mod P). For R=1, every byte is on rail 0.
REQ-018 Accepting TERM with L>0 SHALL move LOAD to SETUP. TERM with L=0 SHALL be consumed silently and the block SHALL stay in LOAD.
REQ-019 SETUP SHALL last exactly 1 cycle and compute start0=0, start1=len0, start2=len0+len1, all widths $clog2(MAX_LEN+1).
REQ-020 EMIT SHALL output plaintext index i=0..L-1 in order, with read address = start[rail(i)] + ptr[rail(i)]. After each out transfer, ptr[rail(i)] SHALL increment and i SHALL advance.
REQ-021 The first out_valid SHALL rise on the 2nd rising edge after the edge that accepted TERM, giving a registered buffer read.
REQ-022 data_c SHALL be held stable while out_valid && !out_ready; the block SHALL sustain one byte per cycle when out_ready=1.
REQ-023 After the transfer of byte L-1, the block SHALL return to LOAD on the same edge. out_valid SHALL be 0 and in_ready SHALL be 1 in the next cycle, and L, all len and ptr registers SHALL clear.
REQ-024 Overflow: a non-TERM byte accepted when L==MAX_LEN SHALL be dropped. err SHALL pulse 1 cycle, and the block SHALL enter SETUP with L=MAX_LEN. A subsequent TERM SHALL then arrive as an empty message (REQ-018).
REQ-025 Input bytes SHALL never be accepted in SETUP/EMIT, and output SHALL never be valid in LOAD.

Reset
REQ-026 While reset=0, the block SHALL enter LOAD with L, len*, ptr*, i cleared; outputs SHALL be out_valid=0, data_c=8'h00, busy=0, err=0, in_ready=1.
REQ-027 Reset asserted mid-LOAD or mid-EMIT SHALL abandon the message immediately (asynchronously), with no further output bytes; buffer contents need not clear.

Verification
REQ-028 Key=2'b10, in: 44 43 49 54 54 45 52 50 41 FA, out_ready=1 -> data_c 44 45 43 52 49 50 54 41 54 ("DECRIPTAT"), 9 bytes back-to-back, first out_valid 2 edges after FA accepted.
REQ-029 Key=2'b11, in: "AEBDFCG" (41 45 42 44 46 43 47) FA -> out 41 42 43 44 45 46 47; len0=2, len1=3, len2=2.
REQ-030 Key=2'b00, in: 31 32 33 FA -> out 31 32 33 unchanged; lone FA in LOAD -> no output, in_ready stays 1.
REQ-031 Key=2'b10 message of REQ-028 with out_ready toggling 1,0,0,1,... -> data_c stable during stalls, same 9-byte sequence, no byte lost or repeated.
REQ-032 MAX_LEN=4, key=2'b10, in: 41 42 43 44 45 -> 45 dropped, err pulses 1 cycle, out 41 43 42 44; following FA ignored.
REQ-033 reset pulled low after 3 of 9 outputs -> out_valid=0 at once, in_ready=1 after release; a new message then decodes correctly.

Source files
------------

// File: rtl/rail_fence_ctrl.sv
// -----------------------------------------------------------------------------
// rail_fence_ctrl
//   Streaming rail-fence (zigzag) decryptor. Ciphertext bytes are buffered
//   while the per-rail lengths are counted. After the end-of-message byte, the
//   plaintext is read back in zigzag order.
//
//   Parameters
//     MAX_LEN   maximum stored message length in bytes (terminator excluded)
//     TERM      end-of-message byte value
//
//   Ports
//     clk       single clock, rising edge
//     reset     asynchronous, active-low reset
//     in_valid  ciphertext byte present on data
//     in_ready  block accepts a byte (high only while loading)
//     data      ciphertext byte
//     key       rail count: 2'b10 = 2 rails, 2'b11 = 3 rails, else 1 rail
//     out_valid plaintext byte present on data_c
//     out_ready sink accepts data_c
//     data_c    decrypted plaintext byte
//     busy      high while computing rail starts or emitting
//     err       one-cycle pulse when a byte is dropped on overflow
// -----------------------------------------------------------------------------
module rail_fence_ctrl #(
  parameter int          MAX_LEN = 32,
  parameter logic [7:0]  TERM    = 8'hFA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data,
  input  logic [1:0] key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_c,
  output logic       busy,
  output logic       err
);

  localparam int            CW    = $clog2(MAX_LEN + 1);
  localparam int            DEPTH = 1 << CW;
  localparam logic [CW-1:0] MAX_L = CW'(MAX_LEN);
  localparam logic [CW-1:0] ONE_C = CW'(1'b1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Number of rails selected by the key (1, 2 or 3).
  function automatic logic [1:0] key_rails(input logic [1:0] k);
    logic [1:0] r;
    case (k)
      2'b10:   r = 2'd2;
      2'b11:   r = 2'd3;
      default: r = 2'd1;
    endcase
    return r;
  endfunction

  // Zigzag rail for a position whose index modulo 4 is ph. For 3 rails the
  // period is 4 (0,1,2,1); for 2 rails it is 2, i.e. the low bit of ph.
  function automatic logic [1:0] rail_of(input logic [1:0] ph, input logic [1:0] nrails);
    logic [1:0] r;
    case (nrails)
      2'd3:    r = (ph == 2'd3) ? 2'd1 : ph;
      2'd2:    r = {1'b0, ph[0]};
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    mem_r [0:DEPTH-1];
  logic [CW-1:0] len_r, len0_r, len1_r, len2_r;
  logic [CW-1:0] start1_r, start2_r;
  logic [CW-1:0] ptr0_r, ptr1_r, ptr2_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    phase_r;
  logic [1:0]    rails_r;
  logic          in_ready_r, busy_r, err_r, out_valid_r;
  logic [7:0]    data_c_r;

  logic          accept_s, is_term_s, ovf_s, wr_s, load_done_s;
  logic          fetch_s, xfer_s, last_s;
  logic [1:0]    rail_s;
  logic [CW-1:0] addr_s;

  assign accept_s    = in_valid && in_ready_r && (state_r == LOAD);
  assign is_term_s   = (data == TERM);
  assign ovf_s       = accept_s && !is_term_s && (len_r == MAX_L);
  assign wr_s        = accept_s && !is_term_s && (len_r != MAX_L);
  assign load_done_s = (accept_s && is_term_s && (len_r != '0)) || ovf_s;
  // Output register is refilled whenever it is empty or being drained.
  assign fetch_s     = (state_r == EMIT) && (cnt_r != len_r) && (!out_valid_r || out_ready);
  assign xfer_s      = out_valid_r && out_ready;
  assign last_s      = (state_r == EMIT) && xfer_s && (cnt_r == len_r);

  // Current rail (shared by load counting and emit addressing) and read address.
  always_comb begin
    rail_s = rail_of(phase_r, rails_r);
    addr_s = ptr0_r;
    case (rail_s)
      2'd0:    addr_s = ptr0_r;
      2'd1:    addr_s = start1_r + ptr1_r;
      2'd2:    addr_s = start2_r + ptr2_r;
      default: addr_s = ptr0_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LOAD: begin
        if (load_done_s) state_s = SETUP;
        else             state_s = LOAD;
      end
      SETUP: state_s = EMIT;
      EMIT: begin
        if (last_s) state_s = LOAD;
        else        state_s = EMIT;
      end
      default: state_s = LOAD;
    endcase
  end

  // Ciphertext store; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[len_r] <= data;
  end

  // Datapath: length/rail counting, rail starts, zigzag read-out, outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_r       <= '0;
      len0_r      <= '0;
      len1_r      <= '0;
      len2_r      <= '0;
      start1_r    <= '0;
      start2_r    <= '0;
      ptr0_r      <= '0;
      ptr1_r      <= '0;
      ptr2_r      <= '0;
      cnt_r       <= '0;
      phase_r     <= 2'd0;
      rails_r     <= 2'd1;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      data_c_r    <= 8'h00;
    end else begin
      err_r      <= ovf_s;
      in_ready_r <= (state_s == LOAD);
      busy_r     <= (state_s != LOAD);
      case (state_r)
        LOAD: begin
          // Key is sampled on the first byte of a message; the first byte is
          // always on rail 0, so counting with the old rails_r is harmless.
          if (accept_s && (len_r == '0)) rails_r <= key_rails(key);
          if (wr_s) begin
            len_r   <= len_r + ONE_C;
            phase_r <= phase_r + 2'd1;
            case (rail_s)
              2'd0:    len0_r <= len0_r + ONE_C;
              2'd1:    len1_r <= len1_r + ONE_C;
              2'd2:    len2_r <= len2_r + ONE_C;
              default: len0_r <= len0_r + ONE_C;
            endcase
          end
        end
        SETUP: begin
          start1_r <= len0_r;
          start2_r <= len0_r + len1_r;
          phase_r  <= 2'd0;
          cnt_r    <= '0;
          ptr0_r   <= '0;
          ptr1_r   <= '0;
          ptr2_r   <= '0;
        end
        EMIT: begin
          if (fetch_s) begin
            data_c_r    <= mem_r[addr_s];
            out_valid_r <= 1'b1;
            cnt_r       <= cnt_r + ONE_C;
            phase_r     <= phase_r + 2'd1;
            case (rail_s)
              2'd0:    ptr0_r <= ptr0_r + ONE_C;
              2'd1:    ptr1_r <= ptr1_r + ONE_C;
              2'd2:    ptr2_r <= ptr2_r + ONE_C;
              default: ptr0_r <= ptr0_r + ONE_C;
            endcase
          end else if (xfer_s) begin
            out_valid_r <= 1'b0;
          end
          if (last_s) begin
            len_r   <= '0;
            len0_r  <= '0;
            len1_r  <= '0;
            len2_r  <= '0;
            ptr0_r  <= '0;
            ptr1_r  <= '0;
            ptr2_r  <= '0;
            cnt_r   <= '0;
            phase_r <= 2'd0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign out_valid = out_valid_r;
  assign data_c    = data_c_r;

endmodule

// File: tb/tb_rail_fence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rail_fence_ctrl
//   Directed bench for rail_fence_ctrl. One instance uses the default
//   MAX_LEN, a second uses MAX_LEN=4 for the overflow case. Inputs are driven
//   on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rail_fence_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] data;
  logic [1:0] key;
  logic       out_ready;
  logic       sel4;

  logic       ir_a, ov_a, busy_a, err_a;
  logic [7:0] dc_a;
  logic       ir_b, ov_b, busy_b, err_b;
  logic [7:0] dc_b;

  logic       ir, ov, bz, er;
  logic [7:0] dc;

  int tests = 0;
  int fails = 0;

  logic [7:0] msg_q [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  rail_fence_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid && !sel4), .in_ready(ir_a),
    .data(data), .key(key), .out_valid(ov_a), .out_ready(out_ready),
    .data_c(dc_a), .busy(busy_a), .err(err_a)
  );

  rail_fence_ctrl #(.MAX_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid && sel4), .in_ready(ir_b),
    .data(data), .key(key), .out_valid(ov_b), .out_ready(out_ready),
    .data_c(dc_b), .busy(busy_b), .err(err_b)
  );

  assign ir = sel4 ? ir_b   : ir_a;
  assign ov = sel4 ? ov_b   : ov_a;
  assign bz = sel4 ? busy_b : busy_a;
  assign er = sel4 ? err_b  : err_a;
  assign dc = sel4 ? dc_b   : dc_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Sends msg_q one byte per cycle; key k1 on the first byte, k_rest after.
  task automatic send_all(input string tag, input logic [1:0] k1, input logic [1:0] k_rest);
    for (int i = 0; i < msg_q.size(); i++) begin
      in_valid = 1'b1;
      data     = msg_q[i];
      key      = (i == 0) ? k1 : k_rest;
      chk({tag, "/in_ready"}, ir, 1);
      chk({tag, "/no_out_in_load"}, ov, 0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called at the falling edge right after the edge that ended loading.
  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic recv(input string tag, input int n, input int stop_at, input int mode);
    int         k;
    int         cyc;
    int         p;
    logic       stalled;
    logic [7:0] held;
    logic       rdy;
    k = 0; cyc = 0; p = 0; stalled = 1'b0; held = 8'h00;
    out_ready = 1'b1;
    chk({tag, "/lat0_valid"}, ov, 0);
    chk({tag, "/lat0_busy"}, bz, 1);
    chk({tag, "/lat0_ready"}, ir, 0);
    @(negedge clk);
    chk({tag, "/lat1_valid"}, ov, 0);
    chk({tag, "/lat1_err"}, er, 0);
    @(negedge clk);
    chk({tag, "/lat2_valid"}, ov, 1);
    while (k < stop_at && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : ((p % 3) == 0);
      p++;
      out_ready = rdy;
      if (mode == 0) chk({tag, "/back_to_back"}, ov, 1);
      if (ov) begin
        if (stalled) chk({tag, "/hold"}, dc, held);
        if (rdy) begin
          chk({tag, "/byte"}, dc, exp_q[k]);
          k++;
          stalled = 1'b0;
        end else begin
          held    = dc;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "/count"}, k, stop_at);
    if (k == n) begin
      chk({tag, "/done_valid"}, ov, 0);
      chk({tag, "/done_ready"}, ir, 1);
    end
  endtask

  initial begin
    sel4 = 1'b0; reset = 1'b0; in_valid = 1'b0; data = 8'h00; key = 2'b00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst/out_valid", ov, 0);
    chk("rst/data_c", dc, 8'h00);
    chk("rst/busy", bz, 0);
    chk("rst/err", er, 0);
    chk("rst/in_ready", ir, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst/in_ready_after", ir, 1);

    // 2 rails; key change after the first byte must be ignored.
    msg_q = '{8'h44, 8'h43, 8'h49, 8'h54, 8'h54, 8'h45, 8'h52, 8'h50, 8'h41, 8'hFA};
    exp_q = '{8'h44, 8'h45, 8'h43, 8'h52, 8'h49, 8'h50, 8'h54, 8'h41, 8'h54};
    send_all("r2", 2'b10, 2'b11);
    recv("r2", 9, 9, 0);

    // 3 rails.
    msg_q = '{8'h41, 8'h45, 8'h42, 8'h44, 8'h46, 8'h43, 8'h47, 8'hFA};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    send_all("r3", 2'b11, 2'b11);
    recv("r3", 7, 7, 0);

    // 1 rail pass-through.
    msg_q = '{8'h31, 8'h32, 8'h33, 8'hFA};
    exp_q = '{8'h31, 8'h32, 8'h33};
    send_all("r1", 2'b00, 2'b00);
    recv("r1", 3, 3, 0);

    // Lone terminator produces nothing.
    msg_q = '{8'hFA};
    send_all("lone", 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("lone/valid", ov, 0);
      chk("lone/ready", ir, 1);
      @(negedge clk);
    end

    // 2 rails with back-pressure.
    msg_q = '{8'h44, 8'h43, 8'h49, 8'h54, 8'h54, 8'h45, 8'h52, 8'h50, 8'h41, 8'hFA};
    exp_q = '{8'h44, 8'h45, 8'h43, 8'h52, 8'h49, 8'h50, 8'h54, 8'h41, 8'h54};
    send_all("stall", 2'b10, 2'b10);
    recv("stall", 9, 9, 1);

    // Reset in the middle of emitting.
    send_all("mid", 2'b10, 2'b10);
    recv("mid", 9, 3, 0);
    #2 reset = 1'b0;
    #1;
    chk("mid/rst_valid", ov, 0);
    chk("mid/rst_ready", ir, 1);
    chk("mid/rst_busy", bz, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("mid/post_valid", ov, 0);
    chk("mid/post_ready", ir, 1);
    msg_q = '{8'h41, 8'h45, 8'h42, 8'h44, 8'h46, 8'h43, 8'h47, 8'hFA};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    send_all("mid_new", 2'b11, 2'b11);
    recv("mid_new", 7, 7, 0);

    // Overflow on the MAX_LEN=4 instance.
    sel4  = 1'b1;
    msg_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    exp_q = '{8'h41, 8'h43, 8'h42, 8'h44};
    send_all("ovf", 2'b10, 2'b10);
    chk("ovf/err_pulse", er, 1);
    in_valid = 1'b1;
    data     = 8'hFA;
    recv("ovf", 4, 4, 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ovf/term_valid", ov, 0);
      chk("ovf/term_ready", ir, 1);
      chk("ovf/term_err", er, 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
